// File: rtl/cordic_instr_encoder_if.sv
// Request/issue bus of the CORDIC custom-0 instruction encoder.
// The slave modport is the encoder side; the master modport is the requester/consumer side.
interface cordic_instr_encoder_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             req_valid_i;
  logic             req_ready_o;
  logic [1:0]       req_op_i;
  logic [4:0]       req_rd_i;
  logic [4:0]       req_rs1_i;
  logic             instr_valid_o;
  logic             instr_ready_i;
  logic [31:0]      instr_o;
  logic             illegal_o;
  logic [CNT_W-1:0] issued_cnt_o;

  modport slave (
    input  req_valid_i, req_op_i, req_rd_i, req_rs1_i, instr_ready_i,
    output req_ready_o, instr_valid_o, instr_o, illegal_o, issued_cnt_o
  );

  modport master (
    output req_valid_i, req_op_i, req_rd_i, req_rs1_i, instr_ready_i,
    input  req_ready_o, instr_valid_o, instr_o, illegal_o, issued_cnt_o
  );
endinterface

// File: rtl/cordic_instr_encoder.sv
// Encodes CORDIC SIN/COS requests into custom-0 RISC-V words and streams them
// through a small FIFO to an instruction consumer.
module cordic_instr_encoder #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  cordic_instr_encoder_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mem_q [DEPTH];

  logic        full_c, empty_c, legal_c, accept_c, push_c, pop_c;
  logic [2:0]  funct3_c;
  logic [31:0] word_c;

  assign full_c  = (state_q == ST_FULL);
  assign empty_c = (state_q == ST_EMPTY);

  // Request decode and encoding.
  assign legal_c  = (bus.req_op_i == 2'b01) || (bus.req_op_i == 2'b10);
  assign funct3_c = (bus.req_op_i == 2'b01) ? 3'b001 : 3'b010;
  assign word_c   = {7'b0000100, 5'b00000, bus.req_rs1_i, funct3_c, bus.req_rd_i, 7'b0001011};

  // Ready is low during reset and whenever full or flushing; it never depends on instr_ready_i.
  assign bus.req_ready_o = rst_ni && !full_c && !flush_i;
  assign accept_c        = bus.req_valid_i && bus.req_ready_o;
  assign push_c          = accept_c && legal_c;
  assign pop_c           = !empty_c && bus.instr_ready_i;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    state_d   = state_q;
    illegal_d = accept_c && !legal_c;
    cnt_d     = cnt_q;

    if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase

    // A pop that coincides with a flush still hands a word out, so it still counts.
    if (pop_c && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end

    if (occ_d == '0)                  state_d = ST_EMPTY;
    else if (occ_d == OCC_W'(DEPTH))  state_d = ST_FULL;
    else                              state_d = ST_PARTIAL;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_EMPTY;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible while the occupancy covers them.
  always_ff @(posedge clk_i) begin
    if (push_c) mem_q[wr_ptr_q] <= word_c;
  end

  assign bus.instr_valid_o = !empty_c;
  assign bus.instr_o       = empty_c ? 32'h0 : mem_q[rd_ptr_q];
  assign bus.illegal_o     = illegal_q;
  assign bus.issued_cnt_o  = cnt_q;

endmodule

// File: tb/tb_cordic_instr_encoder.sv
// Directed bench for cordic_instr_encoder: vector table plus hand-written
// sequences for back-pressure, flush, saturation and mid-operation reset.
module tb_cordic_instr_encoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;

  logic clk;
  logic rst_n;
  logic flush;

  cordic_instr_encoder_if #(.CNT_W(CNT_W)) bus ();

  cordic_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .flush_i(flush),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic        exp_valid;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  function automatic logic [31:0] enc(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1);
    logic [2:0] f3;
    f3 = (op == 2'b01) ? 3'b001 : 3'b010;
    return {7'b0000100, 5'd0, rs1, f3, rd, 7'b0001011};
  endfunction

  function automatic int sat_inc(input int c);
    return (c >= 15) ? 15 : c + 1;
  endfunction

  task automatic set_req(input logic v, input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1);
    bus.req_valid_i = v;
    bus.req_op_i    = op;
    bus.req_rd_i    = rd;
    bus.req_rs1_i   = rs1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [31:0] w [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'b01, 5'd5,  5'd10, 1'b1, 32'h0805128B};
    vecs[1] = '{2'b10, 5'd1,  5'd2,  1'b1, 32'h0801208B};
    vecs[2] = '{2'b11, 5'd3,  5'd4,  1'b0, 32'h0};
    vecs[3] = '{2'b01, 5'd31, 5'd31, 1'b1, 32'h080F9F8B};
    vecs[4] = '{2'b00, 5'd7,  5'd8,  1'b0, 32'h0};
    vecs[5] = '{2'b10, 5'd0,  5'd0,  1'b1, 32'h0800200B};

    rst_n = 1'b0;
    flush = 1'b0;
    set_req(1'b0, 2'b00, 5'd0, 5'd0);
    bus.instr_ready_i = 1'b0;

    #12;
    chk("rst_ready",   32'(bus.req_ready_o),   32'd0);
    chk("rst_valid",   32'(bus.instr_valid_o), 32'd0);
    chk("rst_instr",   bus.instr_o,            32'd0);
    chk("rst_illegal", 32'(bus.illegal_o),     32'd0);
    chk("rst_cnt",     32'(bus.issued_cnt_o),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", 32'(bus.req_ready_o), 32'd1);
    @(negedge clk);

    // Single requests, consumer always ready.
    bus.instr_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, vecs[i].op, vecs[i].rd, vecs[i].rs1);
      #1 chk($sformatf("v%0d_ready", i), 32'(bus.req_ready_o), 32'd1);
      step();
      bus.req_valid_i = 1'b0;
      chk($sformatf("v%0d_valid", i), 32'(bus.instr_valid_o), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) chk($sformatf("v%0d_instr", i), bus.instr_o, vecs[i].exp_instr);
      chk($sformatf("v%0d_illegal", i), 32'(bus.illegal_o), 32'(!vecs[i].exp_valid));
      if (vecs[i].exp_valid) exp_cnt = sat_inc(exp_cnt);
      step();
      chk($sformatf("v%0d_drain", i), 32'(bus.instr_valid_o), 32'd0);
      chk($sformatf("v%0d_ill_end", i), 32'(bus.illegal_o), 32'd0);
      chk($sformatf("v%0d_cnt", i), 32'(bus.issued_cnt_o), 32'(exp_cnt));
    end

    // Back-pressure: DEPTH+1 requests with the consumer stalled.
    bus.instr_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) w[i] = enc((i % 2 == 0) ? 2'b01 : 2'b10, 5'(i + 1), 5'(i + 10));
    for (int i = 0; i < 5; i++) begin
      set_req(1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, 5'(i + 1), 5'(i + 10));
      #1 chk($sformatf("fill%0d_ready", i), 32'(bus.req_ready_o), (i < 4) ? 32'd1 : 32'd0);
      if (i > 0) chk($sformatf("fill%0d_head", i), bus.instr_o, w[0]);
      step();
    end
    bus.instr_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (k < 5) begin
        chk($sformatf("drain%0d_valid", k), 32'(bus.instr_valid_o), 32'd1);
        chk($sformatf("drain%0d_instr", k), bus.instr_o, w[k]);
        exp_cnt = sat_inc(exp_cnt);
      end
      if (k == 0) chk("drain_full_ready", 32'(bus.req_ready_o), 32'd0);
      if (k == 1) chk("drain_5th_ready", 32'(bus.req_ready_o), 32'd1);
      if (k == 2) bus.req_valid_i = 1'b0;
      step();
    end
    chk("drain_empty", 32'(bus.instr_valid_o), 32'd0);
    chk("drain_cnt",   32'(bus.issued_cnt_o),  32'(exp_cnt));

    // Flush with three entries held; the coinciding pop still counts.
    bus.instr_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_req(1'b1, 2'b01, 5'(i + 20), 5'(i));
      step();
    end
    bus.req_valid_i = 1'b0;
    chk("flush_pre_valid", 32'(bus.instr_valid_o), 32'd1);
    flush = 1'b1;
    bus.instr_ready_i = 1'b1;
    #1 chk("flush_ready", 32'(bus.req_ready_o), 32'd0);
    exp_cnt = sat_inc(exp_cnt);
    step();
    flush = 1'b0;
    chk("flush_valid", 32'(bus.instr_valid_o), 32'd0);
    chk("flush_cnt",   32'(bus.issued_cnt_o),  32'(exp_cnt));
    set_req(1'b1, 2'b01, 5'd3, 5'd4);
    step();
    bus.req_valid_i = 1'b0;
    chk("post_flush_valid", 32'(bus.instr_valid_o), 32'd1);
    chk("post_flush_instr", bus.instr_o, enc(2'b01, 5'd3, 5'd4));
    exp_cnt = sat_inc(exp_cnt);
    step();
    chk("post_flush_cnt", 32'(bus.issued_cnt_o), 32'(exp_cnt));

    // Stream 20 words; the 4-bit counter must stick at 15.
    set_req(1'b1, 2'b10, 5'd9, 5'd9);
    for (int c = 0; c < 20; c++) step();
    bus.req_valid_i = 1'b0;
    step();
    step();
    chk("sat_cnt",   32'(bus.issued_cnt_o),  32'd15);
    chk("sat_empty", 32'(bus.instr_valid_o), 32'd0);

    // Reset while full and stalled.
    bus.instr_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 2'b10, 5'(i), 5'(i + 1));
      step();
    end
    bus.req_valid_i = 1'b0;
    #1 chk("full_ready", 32'(bus.req_ready_o), 32'd0);
    chk("full_valid", 32'(bus.instr_valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready",   32'(bus.req_ready_o),   32'd0);
    chk("mid_rst_valid",   32'(bus.instr_valid_o), 32'd0);
    chk("mid_rst_instr",   bus.instr_o,            32'd0);
    chk("mid_rst_illegal", 32'(bus.illegal_o),     32'd0);
    chk("mid_rst_cnt",     32'(bus.issued_cnt_o),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rel_ready", 32'(bus.req_ready_o), 32'd1);
    chk("rel_valid", 32'(bus.instr_valid_o), 32'd0);
    step();
    chk("rel_valid2", 32'(bus.instr_valid_o), 32'd0);
    chk("rel_instr",  bus.instr_o,            32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
